// File: rtl/slave_bus_pkg.sv
// Shared definitions for the req/addr/cmd/wdata -> ack/rdata slave bus.
package slave_bus_pkg;
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } slave_state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/slave_regfile.sv
// DEPTH x N word array: async-reset clear, one write port, one registered read port.
// When not reading, the read register loads rd_fill so the bus sees a defined value.
module slave_regfile #(
  parameter int N     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [N-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  input  logic [N-1:0]             rd_fill,
  output logic [N-1:0]             rd_data
);

  logic [N-1:0] mem_r [DEPTH];
  logic [N-1:0] rd_data_r;

  // storage array with whole-array clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {N{1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {N{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_idx];
    end else begin
      rd_data_r <= rd_fill;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/slave_mem_responder.sv
// Bus slave answering each request with a one-cycle ack after WAIT_CYCLES wait states.
// Optional SLAVE_RESP_ERR_EN adds slave_err and a DEAD_BEEF pattern for out-of-window reads.
module slave_mem_responder
  import slave_bus_pkg::*;
#(
  parameter int           N           = 32,
  parameter int           DEPTH       = 16,
  parameter logic [N-1:0] BASE_ADDR   = {N{1'b0}},
  parameter int           WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         slave_req,
  input  logic [N-1:0] slave_addr,
  input  logic         slave_cmd,
  input  logic [N-1:0] slave_wdata,
  output logic         slave_ack,
`ifdef SLAVE_RESP_ERR_EN
  output logic         slave_err,
`endif
  output logic [N-1:0] slave_rdata
);

  localparam int           AW        = $clog2(DEPTH);
  localparam int           BSH       = $clog2(N / 8);
  localparam logic [N-1:0] WIN_BYTES = N'(DEPTH * N / 8);
  localparam logic [3:0]   WAIT_INIT = 4'(WAIT_CYCLES);

  slave_state_t  state_r, state_nxt_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  logic [N-1:0]  offset_s;
  logic          inwin_s;
  logic [AW-1:0] idx_s;
  logic [AW-1:0] idx_r;
  logic          cmd_r;
  logic          inwin_r;
  logic [N-1:0]  wdata_r;
  logic [AW-1:0] op_idx_s;
  logic          op_cmd_s;
  logic          op_inwin_s;
  logic [N-1:0]  op_wdata_s;
  logic          enter_resp_s;
  logic          wr_en_s;
  logic          rd_en_s;
  logic [N-1:0]  rd_fill_s;
  logic          ack_r;

  assign offset_s = slave_addr - BASE_ADDR;
  assign inwin_s  = (offset_s < WIN_BYTES);
  assign idx_s    = AW'(offset_s >> BSH);

  // state and wait counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // next-state and counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (slave_req) begin
          cnt_nxt_s   = WAIT_INIT;
          state_nxt_s = (WAIT_INIT == 4'd0) ? RESP : WAIT;
        end else begin
          cnt_nxt_s   = 4'd0;
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        cnt_nxt_s   = 4'd0;
        state_nxt_s = IDLE;
      end
      default: begin
        cnt_nxt_s   = 4'd0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // request capture; later changes on the bus are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r   <= {AW{1'b0}};
      cmd_r   <= CMD_READ;
      inwin_r <= 1'b0;
      wdata_r <= {N{1'b0}};
    end else if ((state_r == IDLE) && slave_req) begin
      idx_r   <= idx_s;
      cmd_r   <= slave_cmd;
      inwin_r <= inwin_s;
      wdata_r <= slave_wdata;
    end
  end

  // zero-wait operation enters RESP straight from IDLE, before the capture lands
  assign op_idx_s   = (state_r == IDLE) ? idx_s       : idx_r;
  assign op_cmd_s   = (state_r == IDLE) ? slave_cmd   : cmd_r;
  assign op_inwin_s = (state_r == IDLE) ? inwin_s     : inwin_r;
  assign op_wdata_s = (state_r == IDLE) ? slave_wdata : wdata_r;

  assign enter_resp_s = (state_nxt_s == RESP);
  assign wr_en_s      = enter_resp_s && (op_cmd_s == CMD_WRITE) && op_inwin_s;
  assign rd_en_s      = enter_resp_s && (op_cmd_s == CMD_READ) && op_inwin_s;

  // value loaded into rdata when the array is not read
  always_comb begin
    rd_fill_s = {N{1'b0}};
`ifdef SLAVE_RESP_ERR_EN
    if (enter_resp_s && (op_cmd_s == CMD_READ) && !op_inwin_s) begin
      rd_fill_s = N'(ERR_RDATA);
    end else begin
      rd_fill_s = {N{1'b0}};
    end
`endif
  end

  slave_regfile #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_idx  (op_idx_s),
    .wr_data (op_wdata_s),
    .rd_en   (rd_en_s),
    .rd_idx  (op_idx_s),
    .rd_fill (rd_fill_s),
    .rd_data (slave_rdata)
  );

  // ack pulse, high exactly during RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= enter_resp_s;
    end
  end

  assign slave_ack = ack_r;

`ifdef SLAVE_RESP_ERR_EN
  logic err_r;

  // out-of-window flag, valid only alongside ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= enter_resp_s && !op_inwin_s;
    end
  end

  assign slave_err = err_r;
`endif

endmodule

// File: tb/tb_slave_mem_responder.sv
// Self-checking bench: a zero-wait and a two-wait instance, directed tests plus random traffic
// checked against an array model of the word memory.
module tb_slave_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = 32'd0, addr1 = 32'd0;
  logic        cmd0 = 1'b0, cmd1 = 1'b0;
  logic [31:0] wd0 = 32'd0, wd1 = 32'd0;
  logic        ack0, ack1;
  logic [31:0] rd0, rd1;
`ifdef SLAVE_RESP_ERR_EN
  logic        err0, err1;
  localparam logic [31:0] OOW_RD = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] OOW_RD = 32'h0000_0000;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mem_m [2][16];

  always #5 clk = ~clk;

  slave_mem_responder #(.N(32), .DEPTH(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .slave_req(req0), .slave_addr(addr0), .slave_cmd(cmd0),
    .slave_wdata(wd0), .slave_ack(ack0),
`ifdef SLAVE_RESP_ERR_EN
    .slave_err(err0),
`endif
    .slave_rdata(rd0));

  slave_mem_responder #(.N(32), .DEPTH(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .slave_req(req1), .slave_addr(addr1), .slave_cmd(cmd1),
    .slave_wdata(wd1), .slave_ack(ack1),
`ifdef SLAVE_RESP_ERR_EN
    .slave_err(err1),
`endif
    .slave_rdata(rd1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic r, input logic c, input logic [31:0] a,
                       input logic [31:0] d);
    if (w == 0) begin req0 = r; cmd0 = c; addr0 = a; wd0 = d; end
    else        begin req1 = r; cmd1 = c; addr1 = a; wd1 = d; end
  endtask

  function automatic logic [31:0] obs_ack(input int w);
    return (w == 0) ? {31'd0, ack0} : {31'd0, ack1};
  endfunction

  function automatic logic [31:0] obs_rd(input int w);
    return (w == 0) ? rd0 : rd1;
  endfunction

  // one full transaction, checking ack/rdata every cycle from request to response
  task automatic txn(input int w, input logic c, input logic [31:0] a, input logic [31:0] d,
                     input bit drop);
    int          wc;
    bit          inw;
    int          idx;
    logic [31:0] exp_rd;
    wc     = (w == 0) ? 0 : 2;
    inw    = (a < 32'd64);
    idx    = int'((a >> 2) & 32'd15);
    exp_rd = 32'd0;
    if (c == 1'b0) exp_rd = inw ? mem_m[w][idx] : OOW_RD;
    else if (inw)  mem_m[w][idx] = d;
    @(posedge clk); #1;
    drive(w, 1'b1, c, a, d);
    for (int k = 0; k <= wc + 1; k++) begin
      @(negedge clk);
      chk("ack_timing", obs_ack(w), (k == wc + 1) ? 32'd1 : 32'd0);
      chk("rdata", obs_rd(w), (k == wc + 1) ? exp_rd : 32'd0);
`ifdef SLAVE_RESP_ERR_EN
      chk("err", (w == 0) ? {31'd0, err0} : {31'd0, err1},
          (k == wc + 1 && !inw) ? 32'd1 : 32'd0);
`endif
      @(posedge clk); #1;
      if (drop && k == 0) drive(w, 1'b0, c, a, d);
    end
    drive(w, 1'b0, $urandom_range(0, 1), $urandom, $urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit prev;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++) mem_m[w][i] = 32'd0;

    // reset state
    #2;
    chk("rst_ack1", obs_ack(1), 32'd0);
    chk("rst_rd1", obs_rd(1), 32'd0);
    chk("rst_ack0", obs_ack(0), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: reset mid-WAIT aborts a write
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 32'h4, 32'h1234);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_abort_ack", obs_ack(1), 32'd0);
    end
    @(posedge clk); #1; rst = 1'b0;
    txn(1, 1'b0, 32'h4, 32'h0, 1'b0);

    // 2: write then read with two wait states
    txn(1, 1'b1, 32'h8, 32'hA5A5_A5A5, 1'b0);
    txn(1, 1'b0, 32'h8, 32'h0, 1'b0);

    // 3: zero-wait back-to-back reads with req held high
    for (int i = 0; i < 4; i++) txn(0, 1'b1, 32'(i * 4), 32'(i + 1), 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    prev = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      chk("b2b_ack", obs_ack(0), (c % 2 == 1 && c <= 7) ? 32'd1 : 32'd0);
      chk("b2b_rd", obs_rd(0), (c % 2 == 1 && c <= 7) ? 32'((c + 1) / 2) : 32'd0);
      chk("b2b_no_consec", {31'd0, prev & ack0}, 32'd0);
      prev = ack0;
      @(posedge clk); #1;
      if (c % 2 == 1 && c < 7) addr0 = 32'((c + 1) / 2 * 4);
      if (c == 7) req0 = 1'b0;
    end

    // 4: req dropped during WAIT still completes
    txn(1, 1'b1, 32'h14, 32'h55, 1'b1);
    txn(1, 1'b0, 32'h14, 32'h0, 1'b0);

    // 5: out-of-window write dropped, read returns the fill pattern
    txn(1, 1'b1, 32'h40, 32'hFF, 1'b0);
    txn(1, 1'b0, 32'h0, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h40, 32'h0, 1'b0);

    // 6: byte offset ignored
    txn(1, 1'b1, 32'hC, 32'h77, 1'b0);
    txn(1, 1'b0, 32'hF, 32'h0, 1'b0);

    // random traffic on both instances
    for (int n = 0; n < 120; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      txn(n % 2, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_mem_responder.md
Name: slave_mem_responder

Overview:
Memory-mapped responder that implements the slave end of the team's req/addr/cmd/wdata → ack/rdata bus. It sits behind the master multiplexer's slave port. It holds a small word-addressed register array and answers each request with a one-cycle ack pulse after a fixed number of wait states. It also serves as the reference slave for system-level arbitration tests.

Parameters:
N, 32, data and address width in bits
DEPTH, 16, number of N-bit words in the array (power of two, ≥2)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*N/8
WAIT_CYCLES, 2, wait states inserted between request capture and ack (0..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
slave_req  in  1  request; held by master until ack
slave_addr  in  N  byte address; stable while slave_req=1
slave_cmd  in  1  0=read, 1=write
slave_wdata  in  N  write data; stable while slave_req=1
slave_ack  out  1  one-cycle completion pulse, registered
slave_rdata  out  N  read data, valid only while slave_ack=1, registered
slave_err  out  1  (only with SLAVE_RESP_ERR_EN) out-of-window flag, valid with slave_ack

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, wait counter=0, slave_ack=0, slave_rdata=0, slave_err=0.
  - All DEPTH words cleared to 0.
  - Reset asserted mid-transaction aborts it: no ack, no write.
- Address decode:
  - in_window = (slave_addr − BASE_ADDR) < DEPTH*N/8, compared unsigned in N bits.
  - index = (slave_addr − BASE_ADDR) >> log2(N/8), truncated to log2(DEPTH) bits.
  - Low byte-offset bits are ignored.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if slave_req=1, latch addr/cmd/wdata/in_window. Load counter with WAIT_CYCLES. Go to RESP if WAIT_CYCLES=0, else WAIT.
  - WAIT: counter decrements each cycle; go to RESP when counter reaches 1 (i.e. after WAIT_CYCLES cycles in WAIT).
  - RESP: slave_ack=1 for exactly this cycle. Next state is always IDLE.
- Register timing on the edge entering RESP:
  - slave_ack←1.
  - slave_rdata←mem[index] if read and in_window, else 0.
  - If write and in_window: mem[index]←wdata.
  - Out-of-window writes are dropped.
- On the edge leaving RESP: slave_ack←0, slave_rdata←0, slave_err←0.
- Latency: req first high in IDLE cycle 0 → slave_ack high in cycle 1+WAIT_CYCLES.
- Throughput: one transaction per WAIT_CYCLES+2 cycles; the RESP cycle never captures a new request.
- Handshake: the master removes req, or presents the next transaction, in the cycle after ack. A req that is still high in the IDLE cycle after RESP is a new transaction.
- A req dropped during WAIT does not cancel the transaction: the latched operation completes and ack still pulses.
- Address, cmd and wdata changes after capture are ignored.
- Read-after-write to the same index returns the new data on the next transaction.

Optional Feature:
SLAVE_RESP_ERR_EN
- Defined:
  - slave_err port exists and equals ~in_window (latched) during the RESP cycle, 0 otherwise.
  - Out-of-window reads return 32'hDEAD_BEEF, truncated/zero-extended to N.
- Undefined:
  - No slave_err port.
  - Out-of-window accesses complete silently; reads return 0.

Decomposition:
- Package slave_bus_pkg:
  - CMD_READ=1'b0, CMD_WRITE=1'b1
  - enum slave_state_t {IDLE, WAIT, RESP}
  - ERR_RDATA=32'hDEAD_BEEF
- Sub-module slave_regfile: DEPTH×N array with async reset clear, one write port and one registered read port.
- The FSM, counter and decode stay in slave_mem_responder.

Test Plan:
1. Reset behaviour: rst=1 mid-WAIT during a write to 0x4 with wdata=0x1234 → slave_ack stays 0. After release, a read of 0x4 returns 0x0000_0000.
2. Write then read: WAIT_CYCLES=2, write 0xA5A5_A5A5 to BASE+0x8 (req in cycle 0) → ack in cycle 3. Read of BASE+0x8 → ack 3 cycles after its req, rdata=0xA5A5_A5A5; rdata=0 in every non-ack cycle.
3. Zero-wait back-to-back: WAIT_CYCLES=0, req held high for 4 reads of indices 0..3 preloaded with 1..4 → ack in cycles 1,3,5,7 with rdata 1,2,3,4; never two consecutive ack cycles.
4. Req dropped early: write 0x55 to index 5, deassert req in cycle 1 of WAIT → ack still pulses in cycle 3. A read of index 5 returns 0x55.
5. Out-of-window access: write 0xFF to BASE+DEPTH*4 → ack pulses, array unchanged. With SLAVE_RESP_ERR_EN, a read of the same address gives slave_err=1 and rdata=0xDEAD_BEEF; without the macro, rdata=0.
6. Byte-offset ignore: write 0x77 to BASE+0xC → a read of BASE+0xF returns 0x77.
